// File: rtl/usb_csr_pkg.sv
// Shared register map and types for the USB Wishbone event CSR block.
package usb_csr_pkg;

    localparam logic [6:0]  ADR_CTRL      = 7'h00;
    localparam logic [6:0]  ADR_STATUS    = 7'h04;
    localparam logic [6:0]  ADR_IRQ_EN    = 7'h08;
    localparam logic [6:0]  ADR_EDGE_MODE = 7'h0C;
    localparam logic [6:0]  ADR_CNT_BASE  = 7'h10;
    localparam logic [31:0] RD_DEFAULT    = 32'hDEAD_BEEF;

    typedef struct packed {
        logic gie;
        logic usb_rst;
    } ctrl_t;

    function automatic logic [6:0] cnt_adr(input int unsigned i);
        return ADR_CNT_BASE + 7'(i << 2);
    endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone classic bus bundle with master and slave views.
interface wb_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [6:0]  adr;
    logic [31:0] dat_m2s;
    logic [31:0] dat_s2m;
    logic        ack;

    modport slv (
        input  cyc, stb, we, adr, dat_m2s,
        output dat_s2m, ack
    );

    modport mst (
        output cyc, stb, we, adr, dat_m2s,
        input  dat_s2m, ack
    );

endinterface

// File: rtl/usb_evt_chan.sv
// One event channel: edge/level detect, sticky status and
// saturating counter.
module usb_evt_chan #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             evt_i,
    input  logic             edge_mode_i,
    input  logic             clr_sts_i,
    input  logic             clr_cnt_i,
    output logic             sts_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic evt_q;
    logic hit;

    assign hit = edge_mode_i ? (evt_i & ~evt_q) : evt_i;

    // A hit always wins over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_q <= 1'b0;
            sts_o <= 1'b0;
            cnt_o <= '0;
        end else begin
            evt_q <= evt_i;
            if (hit)
                sts_o <= 1'b1;
            else if (clr_sts_i)
                sts_o <= 1'b0;
            if (clr_cnt_i)
                cnt_o <= hit ? CNT_W'(1) : '0;
            else if (hit && cnt_o != '1)
                cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/usb_wb_event_csr.sv
// Wishbone control/status block: event capture, IRQ and USB
// soft-reset control.
module usb_wb_event_csr
    import usb_csr_pkg::*;
#(
    parameter int   N_EVT    = 8,
    parameter int   CNT_W    = 8,
    parameter logic RST_INIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wb_if.slv                wbs,
    input  logic [N_EVT-1:0] evt_i,
    output logic             usb_rst_o,
    output logic             irq_o
);

    ctrl_t            ctrl;
    logic [N_EVT-1:0] irq_en;
    logic [N_EVT-1:0] edge_mode;
    logic [N_EVT-1:0] sts;
    logic [N_EVT-1:0] clr_sts;
    logic [N_EVT-1:0] clr_cnt;
    logic [CNT_W-1:0] cnt [N_EVT];
    logic             ack_q;
    logic [31:0]      dat_q;
    logic             irq_q;
    logic             acc;
    logic             wr;
    logic [31:0]      rd_data;
    logic             unused_dat;

    assign acc         = wbs.cyc & wbs.stb & ~ack_q;
    assign wr          = acc & wbs.we;
    assign wbs.ack     = ack_q;
    assign wbs.dat_s2m = dat_q;
    assign usb_rst_o   = ctrl.usb_rst;
    assign irq_o       = irq_q;
    assign unused_dat  = ^wbs.dat_m2s;

    for (genvar i = 0; i < N_EVT; i++) begin : g_chan
        usb_evt_chan #(.CNT_W(CNT_W)) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .evt_i       (evt_i[i]),
            .edge_mode_i (edge_mode[i]),
            .clr_sts_i   (clr_sts[i]),
            .clr_cnt_i   (clr_cnt[i]),
            .sts_o       (sts[i]),
            .cnt_o       (cnt[i])
        );
    end

    always_comb begin
        rd_data = RD_DEFAULT;
        clr_cnt = '0;
        clr_sts = '0;
        case (wbs.adr)
            ADR_CTRL:      rd_data = 32'(ctrl);
            ADR_STATUS:    rd_data = 32'(sts);
            ADR_IRQ_EN:    rd_data = 32'(irq_en);
            ADR_EDGE_MODE: rd_data = 32'(edge_mode);
            default:       ;
        endcase
        if (wr && wbs.adr == ADR_STATUS)
            clr_sts = wbs.dat_m2s[N_EVT-1:0];
        for (int i = 0; i < N_EVT; i++) begin
            if (wbs.adr == cnt_adr(i)) begin
                rd_data    = 32'(cnt[i]);
                clr_cnt[i] = wr;
            end
        end
    end

    // Reset drops any in-flight transaction, so its write is lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            ctrl      <= '{gie: 1'b0, usb_rst: RST_INIT};
            irq_en    <= '0;
            edge_mode <= '1;
            irq_q     <= 1'b0;
        end else begin
            ack_q <= acc;
            if (acc)
                dat_q <= rd_data;
            irq_q <= ctrl.gie & |(sts & irq_en);
            if (wr) begin
                case (wbs.adr)
                    ADR_CTRL:      ctrl      <= ctrl_t'(wbs.dat_m2s[1:0]);
                    ADR_IRQ_EN:    irq_en    <= wbs.dat_m2s[N_EVT-1:0];
                    ADR_EDGE_MODE: edge_mode <= wbs.dat_m2s[N_EVT-1:0];
                    default:       ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_wb_event_csr.sv
// Randomised self-checking bench for usb_wb_event_csr against a
// behavioural register-map model.
module tb_usb_wb_event_csr;

    localparam int N = 8;
    localparam int CMAX = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] evt;
    logic         usb_rst_o;
    logic         irq_o;

    wb_if wbs();

    always #5 clk = ~clk;

    usb_wb_event_csr #(
        .N_EVT    (N),
        .CNT_W    (4),
        .RST_INIT (1'b1)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wbs       (wbs),
        .evt_i     (evt),
        .usb_rst_o (usb_rst_o),
        .irq_o     (irq_o)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0]   m_ctrl;
    logic [N-1:0] m_sts, m_irq_en, m_edge, m_prev;
    int           m_cnt [N];
    logic         m_ack, m_irq;
    logic [31:0]  m_dat;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [6:0] a);
        int ia;
        ia = int'(a);
        if (ia == 0) return {30'd0, m_ctrl};
        if (ia == 4) return {24'd0, m_sts};
        if (ia == 8) return {24'd0, m_irq_en};
        if (ia == 12) return {24'd0, m_edge};
        if (ia >= 16 && ia < 16 + 4 * N && ia % 4 == 0)
            return 32'(m_cnt[(ia - 16) / 4]);
        return 32'hDEAD_BEEF;
    endfunction

    // Advance the model from the current inputs, clock once, compare.
    task automatic step();
        logic [N-1:0] hit, clr;
        logic         acc, w, nirq;
        logic [31:0]  r;
        int           ia;
        if (rst) begin
            m_ctrl = 2'b01; m_sts = '0; m_irq_en = '0; m_edge = '1;
            m_prev = '0; m_ack = 1'b0; m_irq = 1'b0; m_dat = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < N; i++)
                hit[i] = m_edge[i] ? (evt[i] & ~m_prev[i]) : evt[i];
            acc  = wbs.cyc & wbs.stb & ~m_ack;
            w    = acc & wbs.we;
            ia   = int'(wbs.adr);
            r    = m_read(wbs.adr);
            nirq = m_ctrl[1] & |(m_sts & m_irq_en);
            clr  = (w && ia == 4) ? wbs.dat_m2s[N-1:0] : '0;
            for (int i = 0; i < N; i++) begin
                if (w && ia == 16 + 4 * i)
                    m_cnt[i] = hit[i] ? 1 : 0;
                else if (hit[i] && m_cnt[i] < CMAX)
                    m_cnt[i]++;
            end
            m_sts = (m_sts & ~clr) | hit;
            if (w && ia == 0) m_ctrl = wbs.dat_m2s[1:0];
            if (w && ia == 8) m_irq_en = wbs.dat_m2s[N-1:0];
            if (w && ia == 12) m_edge = wbs.dat_m2s[N-1:0];
            m_ack = acc;
            if (acc) m_dat = r;
            m_irq  = nirq;
            m_prev = evt;
        end
        @(posedge clk);
        #1;
        chk("ack", 32'(wbs.ack), 32'(m_ack));
        chk("usb_rst_o", 32'(usb_rst_o), 32'(m_ctrl[0]));
        chk("irq_o", 32'(irq_o), 32'(m_irq));
        if (m_ack) chk("dat_s2m", wbs.dat_s2m, m_dat);
    endtask

    task automatic bus(input logic we, input logic [6:0] a,
                       input logic [31:0] d, input logic [N-1:0] ev,
                       output logic [31:0] r);
        wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = we;
        wbs.adr = a; wbs.dat_m2s = d; evt = ev;
        step();
        r = wbs.dat_s2m;
        wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0; evt = '0;
        step();
    endtask

    task automatic rd(input logic [6:0] a, output logic [31:0] r);
        bus(1'b0, a, 32'd0, '0, r);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, a, d, '0, r);
    endtask

    logic [31:0] v;

    initial begin
        rst = 1'b1; evt = '0;
        wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
        wbs.adr = '0; wbs.dat_m2s = '0;
        step(); step();
        rst = 1'b0;
        chk("t1_usb_rst", 32'(usb_rst_o), 32'd1);
        chk("t1_irq", 32'(irq_o), 32'd0);
        rd(7'h00, v); chk("t1_ctrl", v, 32'h1);
        rd(7'h04, v); chk("t1_status", v, 32'h0);
        rd(7'h0C, v); chk("t1_edge", v, 32'hFF);
        rd(7'h40, v); chk("t1_unmapped", v, 32'hDEAD_BEEF);

        evt = 8'h04; repeat (5) step();
        evt = '0; step();
        rd(7'h04, v); chk("t2_status", v, 32'h04);
        rd(7'h18, v); chk("t2_cnt_edge", v, 32'd1);
        wr(7'h0C, 32'hFB);
        evt = 8'h04; repeat (5) step();
        evt = '0; step();
        rd(7'h18, v); chk("t2_cnt_level", v, 32'd6);
        wr(7'h0C, 32'hFF);

        repeat (20) begin
            evt = 8'h01; step();
            evt = '0; step();
        end
        rd(7'h10, v); chk("t3_sat", v, 32'd15);
        wr(7'h10, 32'd0);
        rd(7'h10, v); chk("t3_clr", v, 32'd0);
        bus(1'b1, 7'h10, 32'd0, 8'h01, v);
        rd(7'h10, v); chk("t3_clr_hit", v, 32'd1);

        wr(7'h04, 32'hFF);
        evt = 8'h05; step();
        evt = '0; step();
        rd(7'h04, v); chk("t4_set", v, 32'h05);
        wr(7'h04, 32'h01);
        rd(7'h04, v); chk("t4_w1c", v, 32'h04);
        bus(1'b1, 7'h04, 32'h04, 8'h04, v);
        rd(7'h04, v); chk("t4_evt_wins", v, 32'h04);

        wr(7'h04, 32'hFF);
        wr(7'h08, 32'h02);
        wr(7'h00, 32'h02);
        evt = 8'h01; step();
        evt = '0; step(); step();
        chk("t5_masked", 32'(irq_o), 32'd0);
        evt = 8'h02; step();
        chk("t5_irq_1cyc", 32'(irq_o), 32'd0);
        evt = '0; step();
        chk("t5_irq_2cyc", 32'(irq_o), 32'd1);
        wr(7'h04, 32'h02);
        chk("t5_irq_clr", 32'(irq_o), 32'd0);

        wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b1;
        wbs.adr = 7'h08; wbs.dat_m2s = 32'hAA; rst = 1'b1;
        step();
        chk("t6_ack", 32'(wbs.ack), 32'd0);
        rst = 1'b0; wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
        step();
        rd(7'h00, v); chk("t6_ctrl", v, 32'h1);
        rd(7'h08, v); chk("t6_irq_en", v, 32'h0);

        for (int n = 0; n < 600; n++) begin
            evt     = N'($urandom);
            wbs.cyc = ($urandom_range(0, 3) != 0);
            wbs.stb = ($urandom_range(0, 3) != 0);
            wbs.we  = 1'($urandom);
            wbs.adr = ($urandom_range(0, 3) == 0) ? 7'($urandom)
                    : 7'($urandom_range(0, 11) * 4);
            wbs.dat_m2s = $urandom;
            rst = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
